// File: rtl/mem_arb2.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read memory.
// Grants one request per cycle, registers the memory pins and routes read data back.
module mem_arb2 #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_wr,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_wr,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_i,
  input  logic [DW-1:0] mem_d_o
);

  logic [1:0]    valid;
  logic [1:0]    gnt;
  logic [1:0]    rsp_hit;
  logic          prio_reg;
  logic          prio_next;
  logic          any_gnt;
  logic          gnt_id;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          s1_rd_reg;
  logic          s1_id_reg;
  logic          s2_rd_reg;
  logic          s2_id_reg;

  assign valid = {req1_valid, req0_valid};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic ME = 1'(gi);
      // A port wins when it is alone or when the pointer favours it.
      assign gnt[gi]     = valid[gi] && (!valid[1-gi] || (prio_reg == ME));
      assign rsp_hit[gi] = s2_rd_reg && (s2_id_reg == ME);
    end
  endgenerate

  assign any_gnt    = |gnt;
  assign gnt_id     = gnt[1];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_wr    = gnt_id ? req1_wr    : req0_wr;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;

  always_comb begin
    prio_next = prio_reg;
    if (any_gnt) begin
      prio_next = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg <= 1'b0;
    end else begin
      prio_reg <= prio_next;
    end
  end

  // Address and data hold when idle so the memory sees stable pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_d_i  <= '0;
    end else if (any_gnt) begin
      mem_wr   <= sel_wr;
      mem_addr <= sel_addr;
      mem_d_i  <= sel_wdata;
    end else begin
      mem_wr   <= 1'b0;
    end
  end

  // Stage 2 lines up with the cycle the memory presents read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd_reg <= 1'b0;
      s1_id_reg <= 1'b0;
      s2_rd_reg <= 1'b0;
      s2_id_reg <= 1'b0;
    end else begin
      s1_rd_reg <= any_gnt && !sel_wr;
      s1_id_reg <= gnt_id;
      s2_rd_reg <= s1_rd_reg;
      s2_id_reg <= s1_id_reg;
    end
  end

  assign rsp0_valid = rsp_hit[0];
  assign rsp1_valid = rsp_hit[1];
  assign rsp0_rdata = mem_d_o;
  assign rsp1_rdata = mem_d_o;

endmodule
